regfile_check_ctrl: RTL and testbench
=====================================

Name: regfile_check_ctrl

Overview:
- Post-run checker that sequences the processor/regfile pair for self-checking simulation and FPGA bring-up.
- Runs the CPU for a programmed cycle budget, then takes over regfile read port A. It scans registers 0..NUM_REGS-1 against expected values fetched over a request/ack table interface.
- Reports per-register mismatches, an error count and a pass/fail verdict.
- Sits between the processor's ctrl_readRegA output and the regfile's read-port-A address input.

Parameters:
- NUM_REGS, 32, registers scanned (index width 5, fixed).
- CYC_W, 10, width of the cycle-budget counter.
- ERR_W, 6, width of the error counter (must hold NUM_REGS).

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- num_cycles  in  CYC_W  cycle budget, sampled on start.
- cpu_rs1  in  5  processor's ctrl_readRegA.
- rs1_out  out  5  regfile ctrl_readRegA.
- regA  in  32  regfile data_readRegA.
- cpu_run  out  1  processor clock-enable / not-hold.
- test_mode  out  1  checker owns read port A.
- exp_req  out  1  expected-value request.
- exp_idx  out  5  register index requested.
- exp_ack  in  1  table response strobe.
- exp_valid  in  1  with ack: entry exists (0 = skip register).
- exp_data  in  32  with ack: expected value.
- busy  out  1  high in RUN..SCAN states.
- done  out  1  high in DONE.
- pass  out  1  valid when done: err_count==0.
- err_count  out  ERR_W  mismatches this run.
- fail_valid  out  1  one-cycle pulse per mismatch.
- fail_reg  out  5  register index of the mismatch.
- fail_actual  out  32  actual value read for the mismatch.

Behaviour:
- Reset (async, reset=0):
  - State IDLE; all outputs 0, counters 0.
  - test_mode drops immediately, so rs1_out reverts to cpu_rs1 combinationally.
  - Reset mid-run aborts with no done.
- rs1_out = test_mode ? scan_idx : cpu_rs1 (combinational).
- IDLE: start=1 → latch num_cycles into cyc_left, clear err_count/pass/done, scan_idx=0.
  - Next state RUN if num_cycles≠0, else FETCH.
- RUN: cpu_run=1. Each edge decrements cyc_left; the edge at which cyc_left==1 goes to FETCH.
  - So exactly num_cycles edges with cpu_run=1; cpu_run is 0 the cycle after.
- FETCH:
  - test_mode=1 from here until IDLE.
  - exp_req=1, exp_idx=scan_idx; both held stable until exp_ack.
  - On the edge with exp_ack=1: capture exp_data. exp_valid=1 → SETTLE; exp_valid=0 → NEXT (no compare).
  - exp_ack in the first FETCH cycle is legal (single-cycle fetch).
- SETTLE: one cycle; rs1_out=scan_idx stable.
- COMPARE: regA sampled on this edge.
  - If regA !== captured value: err_count+1, fail_valid=1 in the following cycle, fail_reg=scan_idx, fail_actual=regA.
  - fail_reg/fail_actual hold until the next mismatch. Register 0 is compared like any other.
  - Next state NEXT.
- NEXT: scan_idx==NUM_REGS-1 → DONE; else scan_idx+1 → FETCH.
- DONE: done=1, pass=(err_count==0), test_mode=1, busy=0.
  - start → behaves as from IDLE.
  - No other exit except reset.
- start while busy is ignored.
- exp_ack outside FETCH is ignored.
- Per-register latency: FETCH(1+ack wait) + SETTLE + COMPARE + NEXT = 4 cycles minimum for valid entries, 2 for skipped entries.
- err_count cannot overflow (ERR_W ≥ log2(NUM_REGS)+1).

Test Plan:
- Budget 5, table all exp_valid=0, ack immediate → cpu_run high exactly 5 cycles; done after 32×2 scan cycles; pass=1; err_count=0; fail_valid never pulses.
- Regfile preloaded r3=7, r10=-1; table expects r3=7, r10=-1, rest invalid → pass=1, err_count=0.
- Table expects r3=8 while regA for r3 is 7, plus r31=5 while r31 is 0 → two fail_valid pulses (fail_reg=3 with fail_actual=7, then fail_reg=31 with fail_actual=0); err_count=2; pass=0.
- num_cycles=0 → cpu_run never asserts; FETCH is entered the cycle after start; exp_ack delayed 3 cycles per entry → exp_idx/exp_req held stable throughout each wait.
- reset driven low mid-SETTLE on scan_idx=12 → test_mode, busy and rs1_out override drop without a clock edge; after release, start runs a clean scan from index 0 with err_count starting at 0.
- start pulsed during RUN and again in DONE → first ignored (cyc_left unaffected); second restarts with new num_cycles and clears done/err_count.

Source files
------------

// File: rtl/regfile_check_ctrl.sv
// Post-run regfile checker. It runs the CPU for a set cycle budget, then takes
// over read port A and compares every register against an expected-value table.
module regfile_check_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int CYC_W    = 10,
  parameter int ERR_W    = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CYC_W-1:0] num_cycles,
  input  logic [4:0]       cpu_rs1,
  output logic [4:0]       rs1_out,
  input  logic [31:0]      regA,
  output logic             cpu_run,
  output logic             test_mode,
  output logic             exp_req,
  output logic [4:0]       exp_idx,
  input  logic             exp_ack,
  input  logic             exp_valid,
  input  logic [31:0]      exp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [4:0]       fail_reg,
  output logic [31:0]      fail_actual
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FETCH,
    S_SETTLE,
    S_COMPARE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CYC_W-1:0] cyc_left;
  logic [4:0]       scan_idx;
  logic [31:0]      exp_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nx = (num_cycles != '0) ? S_RUN : S_FETCH;
      S_RUN:          if (cyc_left == CYC_W'(1)) state_nx = S_FETCH;
      S_FETCH:        if (exp_ack) state_nx = exp_valid ? S_SETTLE : S_NEXT;
      S_SETTLE:       state_nx = S_COMPARE;
      S_COMPARE:      state_nx = S_NEXT;
      S_NEXT:         state_nx = (scan_idx == LAST_IDX) ? S_DONE : S_FETCH;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_run   = (state == S_RUN);
    exp_req   = (state == S_FETCH);
    done      = (state == S_DONE);
    busy      = (state != S_IDLE) && (state != S_DONE);
    test_mode = (state != S_IDLE) && (state != S_RUN);
    pass      = done && (err_count == '0);
    exp_idx   = scan_idx;
    rs1_out   = test_mode ? scan_idx : cpu_rs1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_left    <= '0;
      scan_idx    <= '0;
      exp_q       <= '0;
      err_count   <= '0;
      fail_valid  <= 1'b0;
      fail_reg    <= '0;
      fail_actual <= '0;
    end else begin
      fail_valid <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cyc_left  <= num_cycles;
            err_count <= '0;
            scan_idx  <= '0;
          end
        end
        S_RUN:   cyc_left <= cyc_left - CYC_W'(1);
        S_FETCH: if (exp_ack) exp_q <= exp_data;
        S_COMPARE: begin
          // regA has had the whole SETTLE cycle to follow rs1_out = scan_idx.
          if (regA != exp_q) begin
            err_count   <= err_count + ERR_W'(1);
            fail_valid  <= 1'b1;
            fail_reg    <= scan_idx;
            fail_actual <= regA;
          end
        end
        S_NEXT:  if (scan_idx != LAST_IDX) scan_idx <= scan_idx + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_check_ctrl.sv
// Directed bench for regfile_check_ctrl: behavioural regfile plus an
// expected-value table responder with a programmable ack delay.
module tb_regfile_check_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  num_cycles = '0;
  logic [4:0]  cpu_rs1 = 5'd9;
  logic [4:0]  rs1_out;
  logic [31:0] regA;
  logic        cpu_run, test_mode, exp_req;
  logic [4:0]  exp_idx;
  logic        exp_ack = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic        busy, done, pass;
  logic [5:0]  err_count;
  logic        fail_valid;
  logic [4:0]  fail_reg;
  logic [31:0] fail_actual;

  logic [31:0] regs [32];
  logic        tv [32];
  logic [31:0] td [32];
  int          ack_delay = 0;
  int          ack_count = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  fr_q [$];
  logic [31:0] fa_q [$];

  always #5 clock = ~clock;

  assign regA = regs[rs1_out];

  regfile_check_ctrl #(.NUM_REGS(32), .CYC_W(10), .ERR_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_rs1(cpu_rs1), .rs1_out(rs1_out), .regA(regA), .cpu_run(cpu_run),
    .test_mode(test_mode), .exp_req(exp_req), .exp_idx(exp_idx),
    .exp_ack(exp_ack), .exp_valid(exp_valid), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_reg(fail_reg), .fail_actual(fail_actual)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Table responder: acks after ack_delay waiting cycles, checks the request is held.
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clock);
      if (exp_ack) begin
        exp_ack = 1'b0;
      end else if (exp_req) begin
        check("idx_hold", 32'(exp_idx), 32'(ack_count % 32));
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          exp_ack   = 1'b1;
          exp_valid = tv[exp_idx];
          exp_data  = td[exp_idx];
          wait_cnt  = 0;
          ack_count++;
        end
      end else begin
        if (wait_cnt != 0) check("req_hold", 32'(exp_req), 32'd1);
        wait_cnt = 0;
      end
    end
  end

  task automatic clear_tables();
    for (int i = 0; i < 32; i++) begin
      regs[i] = '0;
      tv[i]   = 1'b0;
      td[i]   = '0;
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge clock);
    num_cycles = 10'(n);
    start      = 1'b1;
    ack_count  = 0;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Samples from the first negedge after the start edge until done.
  task automatic wait_done(input int inject_at, input int inject_nc,
                           output int runs, output int busys);
    bit seen;
    runs  = 0;
    busys = 0;
    seen  = 1'b0;
    fr_q.delete();
    fa_q.delete();
    for (int i = 0; i < 4000; i++) begin
      #1;
      if (cpu_run) runs++;
      if (busy) busys++;
      if (fail_valid) begin
        fr_q.push_back(fail_reg);
        fa_q.push_back(fail_actual);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (i == inject_at) begin
        num_cycles = 10'(inject_nc);
        start      = 1'b1;
      end else if (i == inject_at + 1) begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin : main
    int runs, busys;
    bit found;
    clear_tables();

    // Reset state
    #12;
    check("rst_cpu_run", 32'(cpu_run), 0);
    check("rst_test_mode", 32'(test_mode), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_fail_valid", 32'(fail_valid), 0);
    check("rst_exp_req", 32'(exp_req), 0);
    check("rst_rs1_bypass", 32'(rs1_out), 32'd9);
    @(negedge clock);
    reset = 1'b1;

    // T1: budget 5, empty table
    ack_delay = 0;
    pulse_start(5);
    wait_done(-10, 0, runs, busys);
    check("t1_cpu_run", 32'(runs), 32'd5);
    check("t1_busy", 32'(busys), 32'd69);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);
    check("t1_fails", 32'(fr_q.size()), 32'd0);

    // T2: matching r3=7, r10=-1
    regs[3] = 32'd7;  tv[3] = 1'b1;  td[3] = 32'd7;
    regs[10] = 32'hFFFF_FFFF;  tv[10] = 1'b1;  td[10] = 32'hFFFF_FFFF;
    pulse_start(3);
    wait_done(-10, 0, runs, busys);
    check("t2_cpu_run", 32'(runs), 32'd3);
    check("t2_busy", 32'(busys), 32'd71);
    check("t2_pass", 32'(pass), 32'd1);
    check("t2_err", 32'(err_count), 32'd0);

    // T3: r3 expects 8 (is 7), r31 expects 5 (is 0)
    clear_tables();
    regs[3] = 32'd7;  tv[3] = 1'b1;  td[3] = 32'd8;
    tv[31] = 1'b1;  td[31] = 32'd5;
    pulse_start(2);
    wait_done(-10, 0, runs, busys);
    check("t3_busy", 32'(busys), 32'd70);
    check("t3_err", 32'(err_count), 32'd2);
    check("t3_pass", 32'(pass), 32'd0);
    check("t3_nfail", 32'(fr_q.size()), 32'd2);
    if (fr_q.size() == 2) begin
      check("t3_reg0", 32'(fr_q[0]), 32'd3);
      check("t3_act0", fa_q[0], 32'd7);
      check("t3_reg1", 32'(fr_q[1]), 32'd31);
      check("t3_act1", fa_q[1], 32'd0);
    end
    check("t3_hold_reg", 32'(fail_reg), 32'd31);

    // T4: zero budget, ack delayed 3 cycles
    clear_tables();
    regs[3] = 32'd7;  tv[3] = 1'b1;  td[3] = 32'd7;
    regs[10] = 32'hFFFF_FFFF;  tv[10] = 1'b1;  td[10] = 32'hFFFF_FFFF;
    ack_delay = 3;
    pulse_start(0);
    #1;
    check("t4_fetch_now", 32'(exp_req), 32'd1);
    check("t4_no_run", 32'(cpu_run), 32'd0);
    check("t4_done_clr", 32'(done), 32'd0);
    wait_done(-10, 0, runs, busys);
    check("t4_cpu_run", 32'(runs), 32'd0);
    check("t4_busy", 32'(busys), 32'd164);
    check("t4_pass", 32'(pass), 32'd1);

    // T5: reset mid-SETTLE on register 12
    clear_tables();
    tv[5] = 1'b1;  td[5] = 32'd1;
    tv[12] = 1'b1;  td[12] = 32'd0;
    ack_delay = 0;
    pulse_start(1);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      #1;
      if (exp_req && exp_idx == 5'd12 && exp_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("t5_reach12", 32'(found), 32'd1);
    @(posedge clock);
    #2;
    check("t5_settle_mode", 32'(test_mode), 32'd1);
    check("t5_settle_rs1", 32'(rs1_out), 32'd12);
    check("t5_err_before", 32'(err_count), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_mode", 32'(test_mode), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_rs1", 32'(rs1_out), 32'd9);
    check("t5_rst_err", 32'(err_count), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    pulse_start(1);
    #1;
    check("t5_first_idx", 32'(rs1_out), 32'd9);
    wait_done(-10, 0, runs, busys);
    check("t5_err", 32'(err_count), 32'd1);
    check("t5_nfail", 32'(fr_q.size()), 32'd1);
    if (fr_q.size() == 1) check("t5_reg", 32'(fr_q[0]), 32'd5);

    // T6: start during RUN ignored; start in DONE restarts
    clear_tables();
    regs[3] = 32'd7;  tv[3] = 1'b1;  td[3] = 32'd8;
    tv[31] = 1'b1;  td[31] = 32'd5;
    pulse_start(10);
    wait_done(3, 100, runs, busys);
    check("t6_run_ignored", 32'(runs), 32'd10);
    check("t6_err", 32'(err_count), 32'd2);
    pulse_start(4);
    #1;
    check("t6_done_clr", 32'(done), 32'd0);
    check("t6_err_clr", 32'(err_count), 32'd0);
    wait_done(-10, 0, runs, busys);
    check("t6_run2", 32'(runs), 32'd4);
    check("t6_busy2", 32'(busys), 32'd72);
    check("t6_err2", 32'(err_count), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
